// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer
//   Frame sequencer for the digital pixel sensor array. Walks the array through
//   erase, exposure, conversion and readout, then reports completion. Exposure
//   length is programmable per frame. Frames can run back to back, and a frame
//   can be aborted part-way through.
//
// Ports
//   SYSTEM_CLK     single clock, rising edge
//   SYSTEM_RESET   synchronous, active-high reset
//   START          start a frame (honoured only when idle)
//   CONTINUOUS     sampled at end of frame: 1 = start the next frame at once
//   ABORT          return to idle on the next edge (wins over START)
//   EXPOSE_CYCLES  exposure length, latched at each frame start (0 acts as 1)
//   ERASE, EXPOSE, POWER_ENABLE, WRITE_ENABLE, COUNTER_RESET, COUNTER_CLOCK,
//   READ_RESET, READ_CLK_IN   pixel-array strobes (registered)
//   BUSY           high whenever a frame is in progress
//   FRAME_DONE     one-cycle pulse at the end of each completed frame
//   FRAME_COUNT    completed frames, wraps
module pixel_frame_sequencer #(
  parameter int WIDTH                  = 2,
  parameter int HEIGHT                 = 2,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int BIT_DEPTH              = 8,
  parameter int ERASE_CYCLES           = 4,
  parameter int EXP_W                  = 16,
  parameter int FCNT_W                 = 16
) (
  input  logic              SYSTEM_CLK,
  input  logic              SYSTEM_RESET,
  input  logic              START,
  input  logic              CONTINUOUS,
  input  logic              ABORT,
  input  logic [EXP_W-1:0]  EXPOSE_CYCLES,
  output logic              ERASE,
  output logic              EXPOSE,
  output logic              POWER_ENABLE,
  output logic              WRITE_ENABLE,
  output logic              COUNTER_RESET,
  output logic              COUNTER_CLOCK,
  output logic              READ_RESET,
  output logic              READ_CLK_IN,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic [FCNT_W-1:0] FRAME_COUNT
);

  localparam int N_BEATS  = WIDTH * HEIGHT / OUTPUT_BUS_PIXEL_WIDTH;
  localparam int CONV_LEN = 2 * (2 ** BIT_DEPTH);
  localparam int READ_LEN = 2 * N_BEATS;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Cycle counter must reach the last index of the longest phase.
  localparam int CNT_W = max2(max2(EXP_W, $clog2(CONV_LEN)),
                              max2(max2($clog2(READ_LEN), $clog2(ERASE_CYCLES)), 1));

  localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_LEN - 1);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONV_RST, S_CONVERT, S_READ_RST, S_READ, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [EXP_W-1:0]   exp_lat, exp_nxt;
  logic               latch_en;
  logic [FCNT_W-1:0]  fcnt_nxt;
  logic erase_nxt, expose_nxt, pwr_nxt, wen_nxt, crst_nxt, cclk_nxt;
  logic rrst_nxt, rclk_nxt, busy_nxt, done_nxt;

  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    case (state)
      S_IDLE:     if (START && !ABORT) begin
                    state_nxt = S_ERASE;
                    latch_en  = 1'b1;
                  end
      S_ERASE:    if (cnt == ERASE_LAST) state_nxt = S_EXPOSE;
      S_EXPOSE:   if (cnt == CNT_W'(exp_lat - EXP_W'(1))) state_nxt = S_CONV_RST;
      S_CONV_RST: state_nxt = S_CONVERT;
      S_CONVERT:  if (cnt == CONV_LAST) state_nxt = S_READ_RST;
      S_READ_RST: state_nxt = S_READ;
      S_READ:     if (cnt == READ_LAST) state_nxt = S_DONE;
      S_DONE:     if (CONTINUOUS) begin
                    state_nxt = S_ERASE;
                    latch_en  = 1'b1;
                  end else begin
                    state_nxt = S_IDLE;
                  end
      default:    state_nxt = S_IDLE;
    endcase

    // Abort overrides every transition, including a continuous restart.
    if (ABORT && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      latch_en  = 1'b0;
    end

    // Counter restarts from 0 on every state entry.
    cnt_nxt = ((state_nxt == state) && (state != S_IDLE)) ? cnt + CNT_W'(1) : '0;

    exp_nxt = exp_lat;
    if (latch_en)
      exp_nxt = (EXPOSE_CYCLES == '0) ? EXP_W'(1) : EXPOSE_CYCLES;

    // Outputs are decoded from the state being entered so they are valid
    // in its first cycle.
    erase_nxt  = (state_nxt == S_ERASE);
    expose_nxt = (state_nxt == S_EXPOSE);
    pwr_nxt    = (state_nxt == S_CONV_RST) || (state_nxt == S_CONVERT);
    wen_nxt    = pwr_nxt;
    crst_nxt   = (state_nxt == S_CONV_RST);
    // Low on the first convert cycle, then toggles: odd counts are high.
    cclk_nxt   = (state_nxt == S_CONVERT) && cnt_nxt[0];
    rrst_nxt   = (state_nxt == S_READ_RST);
    // Each beat is high then low: even counts are high.
    rclk_nxt   = (state_nxt == S_READ) && !cnt_nxt[0];
    busy_nxt   = (state_nxt != S_IDLE);
    done_nxt   = (state_nxt == S_DONE);

    fcnt_nxt = FRAME_COUNT;
    if (done_nxt) fcnt_nxt = FRAME_COUNT + FCNT_W'(1);
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (SYSTEM_RESET) begin
      state         <= S_IDLE;
      cnt           <= '0;
      ERASE         <= 1'b0;
      EXPOSE        <= 1'b0;
      POWER_ENABLE  <= 1'b0;
      WRITE_ENABLE  <= 1'b0;
      COUNTER_RESET <= 1'b0;
      COUNTER_CLOCK <= 1'b0;
      READ_RESET    <= 1'b0;
      READ_CLK_IN   <= 1'b0;
      BUSY          <= 1'b0;
      FRAME_DONE    <= 1'b0;
      FRAME_COUNT   <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      ERASE         <= erase_nxt;
      EXPOSE        <= expose_nxt;
      POWER_ENABLE  <= pwr_nxt;
      WRITE_ENABLE  <= wen_nxt;
      COUNTER_RESET <= crst_nxt;
      COUNTER_CLOCK <= cclk_nxt;
      READ_RESET    <= rrst_nxt;
      READ_CLK_IN   <= rclk_nxt;
      BUSY          <= busy_nxt;
      FRAME_DONE    <= done_nxt;
      FRAME_COUNT   <= fcnt_nxt;
    end
  end

  // Latched exposure is only read after a frame start has loaded it.
  always_ff @(posedge SYSTEM_CLK) begin
    exp_lat <= exp_nxt;
  end

endmodule
